cordic_gain_comp: RTL

Output stage placed directly after the final CORDIC rotation element (stage ORDER+1 of the 13-element chain). It tracks sample validity through the fixed-latency rotation pipeline and scales the x/y results by the CORDIC gain-compensation constant K. It rounds and saturates the scaled values and buffers them in a small FIFO with a valid/ready output handshake. The residual angle z passes through unscaled.

---
 rtl/cordic_gain_comp.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cordic_gain_comp.sv
// cordic_gain_comp: CORDIC output stage.
// Tracks sample validity, applies gain K with round/saturate, buffers in a FIFO.
module cordic_gain_comp #(
  parameter int DATA_W = 15,
  parameter int FRAC_W = 14,
  parameter int PIPE_DEPTH = 13,
  parameter logic [DATA_W-1:0] K_CONST = 15'h26DD,
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_start,
  input  logic [DATA_W-1:0] x_in,
  input  logic [DATA_W-1:0] y_in,
  input  logic [DATA_W-1:0] z_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] x_out,
  output logic [DATA_W-1:0] y_out,
  output logic [DATA_W-1:0] z_out,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int PW = 2 * DATA_W;

  typedef logic signed [PW-1:0] prod_t;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] z;
  } ent_t;

  localparam prod_t HALF = prod_t'(1 << (FRAC_W - 1));
  localparam prod_t MAXV = prod_t'((1 << (DATA_W - 1)) - 1);
  localparam prod_t MINV = ~MAXV;
  localparam prod_t KEXT = prod_t'({1'b0, K_CONST});

  // Round half up, then clamp into the signed DATA_W range.
  function automatic logic [DATA_W-1:0] rnd_sat(
    input prod_t p
  );
    prod_t s;
    logic [DATA_W-1:0] r;
    s = (p + HALF) >>> FRAC_W;
    r = s[DATA_W-1:0];
    if (s > MAXV) r = MAXV[DATA_W-1:0];
    if (s < MINV) r = MINV[DATA_W-1:0];
    return r;
  endfunction

  // Valid tracker
  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic                  tap;

  assign vld_d = {vld_q[PIPE_DEPTH-2:0], in_start};
  assign tap   = vld_q[PIPE_DEPTH-1];

  // Stage A
  prod_t             px_q, px_d;
  prod_t             py_q, py_d;
  logic [DATA_W-1:0] za_q, za_d;
  logic              va_q, va_d;

  always_comb begin
    px_d = px_q;
    py_d = py_q;
    za_d = za_q;
    va_d = tap;
    if (tap) begin
      px_d = prod_t'($signed(x_in)) * KEXT;
      py_d = prod_t'($signed(y_in)) * KEXT;
      za_d = z_in;
    end
  end

  // Stage B
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] ry_q, ry_d;
  logic [DATA_W-1:0] zb_q, zb_d;
  logic              vb_q, vb_d;

  always_comb begin
    rx_d = rx_q;
    ry_d = ry_q;
    zb_d = zb_q;
    vb_d = va_q;
    if (va_q) begin
      rx_d = rnd_sat(px_q);
      ry_d = rnd_sat(py_q);
      zb_d = za_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld_q <= '0;
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      va_q  <= va_d;
      vb_q  <= vb_d;
    end
  end

  always_ff @(posedge clk) begin
    px_q <= px_d;
    py_q <= py_d;
    za_q <= za_d;
    rx_q <= rx_d;
    ry_q <= ry_d;
    zb_q <= zb_d;
  end

  // Output FIFO
  ent_t           mem_q [FIFO_DEPTH];
  ent_t           wdata;
  logic [AW-1:0]  wp_q, wp_d;
  logic [AW-1:0]  rp_q, rp_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     drop_q, drop_d;
  logic           rd, wr, full, drop;

  assign wdata = '{x: rx_q, y: ry_q, z: zb_q};
  assign full  = (cnt_q == CW'(FIFO_DEPTH));
  assign rd    = out_valid & out_ready;
  // A full FIFO still takes the write when the head leaves on the same edge.
  assign wr    = vb_q & (~full | rd);
  assign drop  = vb_q & ~wr;

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q | drop;
    drop_d = drop_q;
    if (wr) wp_d = wp_q + 1'b1;
    if (rd) rp_d = rp_q + 1'b1;
    unique case (1'b1)
      (wr & ~rd): cnt_d = cnt_q + 1'b1;
      (rd & ~wr): cnt_d = cnt_q - 1'b1;
      default:    cnt_d = cnt_q;
    endcase
    if (drop && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr) begin
      mem_q[wp_q] <= wdata;
    end
  end

  assign out_valid  = (cnt_q != '0);
  assign x_out      = mem_q[rp_q].x;
  assign y_out      = mem_q[rp_q].y;
  assign z_out      = mem_q[rp_q].z;
  assign fifo_count = cnt_q;
  assign overflow   = ovf_q;
  assign drop_cnt   = drop_q;

endmodule
